inference_controller: RTL and testbench

- Sequences a chain of NUM_LAYERS dense layers for one inference.
- Accepts a start handshake, then issues a one-cycle start pulse to each layer in turn, waiting for that layer's done before moving on.
- After the last layer completes, scans the final-layer outputs for the argmax and presents class/score on a valid/ready result port.
- A per-layer watchdog traps a hung layer into a sticky error state.

---
 rtl/nn_pkg.sv | 26 ++
 rtl/inference_controller_argmax_scan.sv | 54 +++++
 rtl/inference_controller.sv | 130 +++++++++++++
 tb/tb_inference_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer inference engine.
package nn_pkg;

  // Activation selection used by the dense layer modules.
  typedef enum logic [1:0] {
    ACT_LINEAR,
    ACT_RELU,
    ACT_LEAKY_RELU
  } activation_t;

  // Inference controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ARGMAX,
    DONE,
    ERROR
  } ctrl_state_t;

  // Width of an index into n items. Never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inference_controller_argmax_scan.sv
// Sequential argmax over a vector of signed values, one element per cycle.
// A start pulse seeds the best value with element 0. Element i is compared
// in scan cycle i. done is high during the cycle that handles the last
// element. Ties keep the lower index.
module argmax_scan
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 10
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic signed [DATA_WIDTH-1:0]          values [NUM_OUTPUTS],
  output logic                                  done,
  output logic [idx_width(NUM_OUTPUTS)-1:0]     max_index,
  output logic signed [DATA_WIDTH-1:0]          max_value
);

  localparam int IW = idx_width(NUM_OUTPUTS);

  logic [IW-1:0] pos;
  logic          running;

  assign done = running && (pos == IW'(NUM_OUTPUTS - 1));

  // Seed on start, then walk the vector, replacing only on strictly greater.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!reset) begin
      running   <= 1'b0;
      pos       <= '0;
      max_index <= '0;
      max_value <= '0;
    end else if (start) begin
      running   <= 1'b1;
      pos       <= IW'(1);
      max_index <= '0;
      max_value <= values[0];
    end else if (running) begin
      if (values[pos] > max_value) begin
        max_index <= pos;
        max_value <= values[pos];
      end
      if (done) begin
        running <= 1'b0;
      end else begin
        pos <= pos + IW'(1);
      end
    end
  end

endmodule

// File: rtl/inference_controller.sv
// Sequences a chain of dense layers for one inference: start pulse per
// layer, wait for that layer's done rising edge under a watchdog, then an
// argmax scan of the final layer whose result is offered on a valid/ready
// port. A watchdog expiry parks the controller in a sticky error state.
module inference_controller
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LAYERS     = 3,
  parameter int NUM_OUTPUTS    = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NUM_LAYERS-1:0]                 layer_start,
  input  logic [NUM_LAYERS-1:0]                 layer_done,
  input  logic signed [DATA_WIDTH-1:0]          final_outputs [NUM_OUTPUTS],
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [idx_width(NUM_OUTPUTS)-1:0]     result_class,
  output logic signed [DATA_WIDTH-1:0]          result_score,
  output logic [idx_width(NUM_LAYERS)-1:0]      current_layer,
  output logic                                  busy,
  output logic                                  error
);

  localparam int KW = idx_width(NUM_LAYERS);
  localparam int TW = idx_width(TIMEOUT_CYCLES);

  ctrl_state_t           state, state_next;
  logic [KW-1:0]         k;
  logic [TW-1:0]         timer;
  logic [NUM_LAYERS-1:0] done_prev;

  logic done_edge;
  logic timer_expired;
  logic last_layer;
  logic scan_start;
  logic scan_done;

  // A done level that was already high before this WAIT (left over from a
  // previous inference) never produces an edge, so it cannot advance us.
  assign done_edge     = layer_done[k] & ~done_prev[k];
  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_layer    = (k == KW'(NUM_LAYERS - 1));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a done edge takes priority over watchdog expiry.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:   if (in_valid) state_next = START;
      START:  state_next = WAIT;
      WAIT: begin
        if (done_edge) begin
          state_next = last_layer ? ARGMAX : START;
        end else if (timer_expired) begin
          state_next = ERROR;
        end
      end
      ARGMAX: if (scan_done) state_next = DONE;
      DONE:   if (result_ready) state_next = IDLE;
      ERROR:  state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Layer index, watchdog counter and done history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k         <= '0;
      timer     <= '0;
      done_prev <= '0;
    end else begin
      done_prev <= layer_done;
      case (state)
        IDLE: if (in_valid) k <= '0;
        START: timer <= '0;
        WAIT: begin
          if (done_edge) begin
            if (!last_layer) k <= k + KW'(1);
          end else if (!timer_expired) begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs plus the scan launch on the final layer's done edge.
  always_comb begin
    layer_start   = '0;
    in_ready      = (state == IDLE);
    result_valid  = (state == DONE);
    busy          = (state == START) || (state == WAIT) || (state == ARGMAX);
    error         = (state == ERROR);
    current_layer = k;
    scan_start    = (state == WAIT) && done_edge && last_layer;
    if (state == START) layer_start[k] = 1'b1;
  end

  // The scan registers double as the result registers: they hold through
  // DONE and IDLE until the next scan is seeded.
  argmax_scan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_OUTPUTS (NUM_OUTPUTS)
  ) u_argmax (
    .clock     (clock),
    .reset     (reset),
    .start     (scan_start),
    .values    (final_outputs),
    .done      (scan_done),
    .max_index (result_class),
    .max_value (result_score)
  );

endmodule

// File: tb/tb_inference_controller.sv
// Self-checking bench for inference_controller: behavioural layer models,
// a reference argmax/latency model, directed and randomized inferences.
module tb_inference_controller;

  localparam int DW = 16;
  localparam int NL = 2;
  localparam int NO = 4;
  localparam int TO = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NL-1:0]        layer_start;
  logic [NL-1:0]        ld = '0;
  logic signed [DW-1:0] fo [NO];
  logic                 result_valid;
  logic                 result_ready = 1'b0;
  logic [1:0]           result_class;
  logic signed [DW-1:0] result_score;
  logic [0:0]           current_layer;
  logic                 busy;
  logic                 error;

  int total = 0;
  int bad   = 0;

  // Layer model configuration (written by the main sequence only).
  int dly  [NL];
  int drop [NL];
  bit hang [NL];

  // Layer model state (written by the layer process only).
  int el  [NL];
  bit act [NL];

  // Monitor state (written by the monitor process only).
  int cyc = 0;
  int pulse_total [NL];
  int pulse_last  [NL];
  int busy_total  = 0;
  int multi_total = 0;

  inference_controller #(
    .DATA_WIDTH     (DW),
    .NUM_LAYERS     (NL),
    .NUM_OUTPUTS    (NO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .layer_start   (layer_start),
    .layer_done    (ld),
    .final_outputs (fo),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_class  (result_class),
    .result_score  (result_score),
    .current_layer (current_layer),
    .busy          (busy),
    .error         (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Dense layer stand-in: on its start pulse it drops done after drop[j]
  // cycles and raises it dly[j]+1 cycles after the pulse (unless hung).
  always @(negedge clock) begin
    for (int j = 0; j < NL; j++) begin
      if (layer_start[j]) begin
        el[j]  = 0;
        act[j] = 1'b1;
      end else if (act[j]) begin
        el[j]++;
        if (el[j] == drop[j]) ld[j] = 1'b0;
        if (el[j] == dly[j] + 1) begin
          act[j] = 1'b0;
          if (!hang[j]) ld[j] = 1'b1;
        end
      end
    end
  end

  // Record start pulses, one-hot violations and busy cycles.
  always @(negedge clock) begin
    for (int j = 0; j < NL; j++) begin
      if (layer_start[j]) begin
        pulse_total[j]++;
        pulse_last[j] = cyc;
      end
    end
    if ($countones(layer_start) > 1) multi_total++;
    if (busy) busy_total++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: max value first, then the lowest index holding it.
  task automatic ref_argmax(input logic signed [DW-1:0] v [NO], output int cls,
                            output logic signed [DW-1:0] sc);
    sc = v[0];
    foreach (v[i]) if (v[i] > sc) sc = v[i];
    cls = -1;
    for (int i = NO - 1; i >= 0; i--) if (v[i] == sc) cls = i;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    check({tag, ".layer_start"}, 32'(layer_start), 0);
    check({tag, ".result_valid"}, 32'(result_valid), 0);
    check({tag, ".result_class"}, 32'(result_class), 0);
    check({tag, ".result_score"}, 32'(result_score), 0);
    check({tag, ".current_layer"}, 32'(current_layer), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".error"}, 32'(error), 0);
  endtask

  // One full inference with latency, pulse and result checks, then bp
  // cycles of backpressure (optionally poking in_valid) and the handshake.
  task automatic run_inference(input string tag, input logic signed [DW-1:0] v [NO],
                               input int bp, input bit poke);
    int s_pulse [NL];
    int s_busy, s_multi, acc, n, exp_n, cls, start_idx;
    logic signed [DW-1:0] sc;
    logic [1:0] hold_cls;
    logic signed [DW-1:0] hold_sc;
    bit got, stable, blocked;

    @(negedge clock);
    check({tag, ".ready_before"}, 32'(in_ready), 1);
    fo = v;
    foreach (s_pulse[j]) s_pulse[j] = pulse_total[j];
    s_busy  = busy_total;
    s_multi = multi_total;

    @(posedge clock); #1 in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    acc = cyc;

    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (result_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".valid_seen"}, 32'(got), 1);

    exp_n = NO;
    foreach (dly[j]) exp_n += dly[j] + 2;
    n = cyc - acc + 1;
    check({tag, ".latency"}, 32'(n), 32'(exp_n));
    check({tag, ".busy_cycles"}, 32'(busy_total - s_busy), 32'(exp_n - 1));
    check({tag, ".onehot"}, 32'(multi_total - s_multi), 0);
    start_idx = 1;
    for (int j = 0; j < NL; j++) begin
      check($sformatf("%s.pulses%0d", tag, j), 32'(pulse_total[j] - s_pulse[j]), 1);
      check($sformatf("%s.start_at%0d", tag, j), 32'(pulse_last[j] - acc + 1), 32'(start_idx));
      start_idx += dly[j] + 2;
    end

    ref_argmax(v, cls, sc);
    check({tag, ".class"}, 32'(result_class), 32'(cls));
    check({tag, ".score"}, 32'(result_score), 32'(sc));

    hold_cls = result_class;
    hold_sc  = result_score;
    stable   = 1'b1;
    blocked  = 1'b1;
    for (int b = 0; b < bp; b++) begin
      @(posedge clock); #1;
      if (poke) in_valid = 1'b1;
      @(negedge clock);
      if (result_valid !== 1'b1 || result_class !== hold_cls || result_score !== hold_sc)
        stable = 1'b0;
      if (in_ready !== 1'b0) blocked = 1'b0;
    end
    in_valid = 1'b0;
    if (bp > 0) begin
      check({tag, ".bp_stable"}, 32'(stable), 1);
      check({tag, ".bp_in_ready_low"}, 32'(blocked), 1);
    end

    @(posedge clock); #1 result_ready = 1'b1;
    @(posedge clock); #1 result_ready = 1'b0;
    @(negedge clock);
    check({tag, ".idle_ready"}, 32'(in_ready), 1);
    check({tag, ".idle_valid"}, 32'(result_valid), 0);
    check({tag, ".idle_class_held"}, 32'(result_class), 32'(cls));
    check({tag, ".idle_score_held"}, 32'(result_score), 32'(sc));
    check({tag, ".no_extra_pulse"}, 32'(pulse_total[0] - s_pulse[0]), 1);
  endtask

  initial begin
    logic signed [DW-1:0] v [NO];
    int acc, err_idx;

    foreach (dly[j]) begin
      dly[j]  = 1;
      drop[j] = 1;
      hang[j] = 1'b0;
      pulse_total[j] = 0;
      pulse_last[j]  = 0;
      el[j]  = 0;
      act[j] = 1'b0;
    end
    foreach (fo[i]) fo[i] = '0;

    // Reset state.
    #12;
    check_reset_values("reset");
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("post_reset");

    // Basic run with backpressure and an in_valid poke while DONE.
    dly[0] = 2; dly[1] = 1;
    v = '{16'sd5, -16'sd3, 16'sd9, 16'sd2};
    run_inference("basic", v, 10, 1'b1);

    // Ties and negatives (layer 0 done is now stale-high from the last run).
    v = '{-16'sd7, -16'sd2, -16'sd2, -16'sd9};
    run_inference("ties_neg", v, 0, 1'b0);
    v = '{16'sd4, 16'sd4, 16'sd4, 16'sd4};
    run_inference("all_equal", v, 1, 1'b0);

    // Stale done held through the first WAIT cycle, re-raised later.
    dly[0] = 4; drop[0] = 2; dly[1] = 2; drop[1] = 2;
    v = '{16'sd1, 16'sd3, -16'sd8, 16'sd3};
    run_inference("stale_done", v, 0, 1'b0);

    // Done edge on the very cycle the watchdog would expire.
    dly[0] = TO - 1; dly[1] = TO - 1; drop[0] = 1; drop[1] = 1;
    v = '{-16'sd32768, 16'sd32767, 16'sd0, -16'sd1};
    run_inference("edge_at_timeout", v, 0, 1'b0);

    // Randomized inferences.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < NL; j++) begin
        dly[j]  = int'($urandom_range(1, TO - 1));
        drop[j] = (dly[j] >= 2 && $urandom_range(0, 1) == 1) ? 2 : 1;
      end
      foreach (v[i]) v[i] = DW'(int'($urandom_range(0, 6)) - 3);
      run_inference($sformatf("rand%0d", r), v, int'($urandom_range(0, 3)), 1'b0);
    end

    // Watchdog: layer 1 never completes.
    dly[0] = 1; drop[0] = 1; dly[1] = 3; drop[1] = 1; hang[1] = 1'b1;
    @(posedge clock); #1 in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    acc = cyc;
    err_idx = (dly[0] + 2) + 1 + TO + 1;
    repeat (err_idx - 1) @(negedge clock);
    check("wdog.pre_error", 32'(error), 0);
    check("wdog.pre_busy", 32'(busy), 1);
    @(negedge clock);
    check("wdog.cycle", 32'(cyc - acc + 1), 32'(err_idx));
    check("wdog.error", 32'(error), 1);
    check("wdog.layer", 32'(current_layer), 1);
    check("wdog.in_ready", 32'(in_ready), 0);
    check("wdog.busy", 32'(busy), 0);
    @(posedge clock); #1 in_valid = 1'b1;
    repeat (5) @(negedge clock);
    check("wdog.sticky", 32'(error), 1);
    check("wdog.no_start", 32'(layer_start), 0);
    check("wdog.stay_blocked", 32'(in_ready), 0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values("wdog_reset");
    @(negedge clock) reset = 1'b1;
    hang[1] = 1'b0;

    // Asynchronous reset in the middle of layer 1's WAIT.
    dly[0] = 1; dly[1] = 6;
    @(posedge clock); #1 in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    acc = cyc;
    repeat (7) @(negedge clock);
    check("midwait.layer", 32'(current_layer), 1);
    check("midwait.busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    @(posedge clock); #1 reset = 1'b1;
    v = '{16'sd0, -16'sd5, 16'sd6, 16'sd7};
    run_inference("after_reset", v, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
